// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming datapath.
//   DATA_WIDTH         : signed pixel width carried in the low tdata bits
//   C_AXIS_TDATA_WIDTH : AXI-Stream tdata width used on every stream
//   pixel_t            : signed pixel type
//   row_state_t        : even/odd input row tracking used by the pooling stage
package cnn_pkg;

  localparam int DATA_WIDTH         = 16;
  localparam int C_AXIS_TDATA_WIDTH = 32;

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_t;

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer for the max-pool stage.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable, rdata loads mem[raddr] on the rising edge
//   rdata : registered read data, holds its value while re is low
// Contents are not reset; every entry is written before it is read.
module pool_line_buf #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/maxpool_relu_axis.sv
// Streaming ReLU + 2x2/stride-2 max-pool on an AXI-Stream pixel stream.
//   clk, resetn        : clock, asynchronous active-low reset
//   s_axis_*           : input pixels, raster order, tuser = start of frame,
//                        tlast = end of line, pixel in tdata[DATA_WIDTH-1:0]
//   m_axis_*           : one rectified, pooled pixel per 2x2 window,
//                        tdata zero-extended, tstrb all ones
//   err_odd_line       : sticky, a line ended on an even column
//   err_overflow       : sticky, a line ran past MAX_LINE_WIDTH
// Horizontal maxima of even rows are parked in pool_line_buf and combined
// with the horizontal maxima of the following odd row.
module maxpool_relu_axis
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH         = cnn_pkg::DATA_WIDTH,
  parameter int C_AXIS_TDATA_WIDTH = cnn_pkg::C_AXIS_TDATA_WIDTH,
  parameter int MAX_LINE_WIDTH     = 128
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            err_odd_line,
  output logic                            err_overflow
);

  localparam int BUF_DEPTH = MAX_LINE_WIDTH / 2;
  localparam int ADDR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // One extra code so the column counter can saturate at MAX_LINE_WIDTH.
  localparam int COL_W     = $clog2(MAX_LINE_WIDTH + 1);

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t relu(input pix_t v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction

  row_state_t       row;
  logic [COL_W-1:0] col;
  logic             col_odd;  // column parity, keeps counting past saturation
  pix_t             hold;
  logic             first_pending;

  logic             acc_p0;
  pix_t             pix_p0;
  row_state_t       row_p0;
  logic [COL_W-1:0] col_p0;
  logic             odd_p0;
  logic             in_range_p0;
  pix_t             hmax_p0;
  pix_t             vmax_p0;
  pix_t             relu_p0;
  logic             buf_we_p0;
  logic             buf_re_p0;
  logic             ld_p0;
  logic [ADDR_W-1:0] buf_addr_p0;
  logic [DATA_WIDTH-1:0] buf_rdata;
  pix_t             rd_p1;

  logic                          vld_p1;
  logic [C_AXIS_TDATA_WIDTH-1:0] data_p1;
  logic                          last_p1;
  logic                          user_p1;

  logic unused_tdata_hi;
  assign unused_tdata_hi = ^s_axis_tdata[C_AXIS_TDATA_WIDTH-1:DATA_WIDTH];

  // ---- p0: accepted input beat; tuser restarts row/column before use ----
  assign s_axis_tready = !vld_p1 || m_axis_tready;
  assign acc_p0        = s_axis_tvalid && s_axis_tready;
  assign pix_p0        = pix_t'(s_axis_tdata[DATA_WIDTH-1:0]);
  assign row_p0        = s_axis_tuser ? ROW_EVEN : row;
  assign col_p0        = s_axis_tuser ? '0 : col;
  assign odd_p0        = s_axis_tuser ? 1'b0 : col_odd;
  assign in_range_p0   = col_p0 < COL_W'(MAX_LINE_WIDTH);
  assign hmax_p0       = smax(hold, pix_p0);
  assign rd_p1         = pix_t'(buf_rdata);
  assign vmax_p0       = smax(rd_p1, hmax_p0);
  assign relu_p0       = relu(vmax_p0);
  assign buf_addr_p0   = col_p0[ADDR_W:1];
  assign buf_we_p0     = acc_p0 && in_range_p0 && (row_p0 == ROW_EVEN) &&  odd_p0;
  assign buf_re_p0     = acc_p0 && in_range_p0 && (row_p0 == ROW_ODD)  && !odd_p0;
  assign ld_p0         = acc_p0 && in_range_p0 && (row_p0 == ROW_ODD)  &&  odd_p0;

  pool_line_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_line_buf (
    .clk  (clk),
    .we   (buf_we_p0),
    .waddr(buf_addr_p0),
    .wdata(hmax_p0),
    .re   (buf_re_p0),
    .raddr(buf_addr_p0),
    .rdata(buf_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row           <= ROW_EVEN;
      col           <= '0;
      col_odd       <= 1'b0;
      hold          <= '0;
      first_pending <= 1'b0;
      err_odd_line  <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (acc_p0) begin
      if (!odd_p0) hold <= pix_p0;
      if (s_axis_tlast) begin
        col     <= '0;
        col_odd <= 1'b0;
        row     <= (row_p0 == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end else begin
        col_odd <= !odd_p0;
        col     <= in_range_p0 ? col_p0 + COL_W'(1) : col_p0;
      end
      if (s_axis_tuser)  first_pending <= 1'b1;
      else if (ld_p0)    first_pending <= 1'b0;
      // tuser clears the sticky flags before this beat can set them again
      err_odd_line <= (err_odd_line && !s_axis_tuser) || (s_axis_tlast && !odd_p0);
      err_overflow <= (err_overflow && !s_axis_tuser) || !in_range_p0;
    end
  end

  // ---- p1: output register, holds until drained ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      user_p1 <= 1'b0;
    end else if (ld_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= {{(C_AXIS_TDATA_WIDTH-DATA_WIDTH){1'b0}}, relu_p0};
      last_p1 <= s_axis_tlast;
      user_p1 <= first_pending;
    end else if (m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tuser  = user_p1;
  assign m_axis_tstrb  = '1;

endmodule

// File: tb/tb_maxpool_relu_axis.sv
// Bench for maxpool_relu_axis: two instances (line limit 128 and 4) share
// one input stream; a frame-level model predicts each instance's outputs
// and error flags, checked every cycle, plus literal expectations per test.
module tb_maxpool_relu_axis;

  localparam int TW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          s_tvalid, s_tlast, s_tuser, m_tready;
  logic [TW-1:0] s_tdata;

  logic          a_s_tready, a_m_tvalid, a_m_tlast, a_m_tuser, a_err_odd, a_err_ovf;
  logic [TW-1:0] a_m_tdata;
  logic [3:0]    a_m_tstrb;
  logic          b_s_tready, b_m_tvalid, b_m_tlast, b_m_tuser, b_err_odd, b_err_ovf;
  logic [TW-1:0] b_m_tdata;
  logic [3:0]    b_m_tstrb;

  maxpool_relu_axis #(.DATA_WIDTH(16), .C_AXIS_TDATA_WIDTH(TW), .MAX_LINE_WIDTH(128)) dut_a (
    .clk(clk), .resetn(resetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(a_s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(a_m_tdata),
    .m_axis_tstrb(a_m_tstrb), .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser),
    .err_odd_line(a_err_odd), .err_overflow(a_err_ovf)
  );

  maxpool_relu_axis #(.DATA_WIDTH(16), .C_AXIS_TDATA_WIDTH(TW), .MAX_LINE_WIDTH(4)) dut_b (
    .clk(clk), .resetn(resetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(b_m_tdata),
    .m_axis_tstrb(b_m_tstrb), .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
    .err_odd_line(b_err_odd), .err_overflow(b_err_ovf)
  );

  typedef struct {
    int data;
    bit last;
    bit user;
  } out_t;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 -> limit 128, 1 -> limit 4
  int   erow [2][256];
  int   orow [2][256];
  int   mcol [2];
  bit   modd [2];
  bit   mfp  [2];
  bit   mer_odd [2];
  bit   mer_ovf [2];
  out_t qa[$];
  out_t qb[$];
  out_t capa[$];
  out_t capb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int relu_i(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcol[i] = 0; modd[i] = 0; mfp[i] = 0; mer_odd[i] = 0; mer_ovf[i] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  // Pool each 2x2 window from full stored rows when its last pixel arrives.
  task automatic model_beat(input int i, input int mx, input int px, input bit l, input bit u);
    int   c;
    out_t o;
    if (u) begin
      modd[i] = 0; mcol[i] = 0; mer_odd[i] = 0; mer_ovf[i] = 0; mfp[i] = 1;
    end
    c = mcol[i];
    if (c >= mx) begin
      mer_ovf[i] = 1;
    end else if (!modd[i]) begin
      erow[i][c] = px;
    end else begin
      orow[i][c] = px;
      if (c % 2 == 1) begin
        o.data = relu_i(max_i(max_i(erow[i][c-1], erow[i][c]), max_i(orow[i][c-1], px)));
        o.last = l;
        o.user = mfp[i];
        mfp[i] = 0;
        if (i == 0) qa.push_back(o); else qb.push_back(o);
      end
    end
    if (l) begin
      if (c % 2 == 0) mer_odd[i] = 1;
      modd[i] = !modd[i];
      mcol[i] = 0;
    end else begin
      mcol[i] = c + 1;
    end
  endtask

  task automatic cmp(input string tag, input bit has, input out_t e,
                     input logic mv, input logic [TW-1:0] md, input logic ml, input logic mu,
                     input logic [3:0] ms, input logic st, input logic eo, input logic ev,
                     input bit xo, input bit xv);
    check({tag, "_tvalid"}, int'(mv), int'(has));
    if (has || !resetn) begin
      check({tag, "_tdata"}, int'(md), e.data);
      check({tag, "_tlast"}, int'(ml), int'(e.last));
      check({tag, "_tuser"}, int'(mu), int'(e.user));
    end
    check({tag, "_tstrb"}, int'(ms), 15);
    check({tag, "_s_tready"}, int'(st), int'(!has || m_tready));
    check({tag, "_err_odd"}, int'(eo), int'(xo));
    check({tag, "_err_ovf"}, int'(ev), int'(xv));
  endtask

  task automatic cmp_all();
    out_t e0, e1;
    e0 = '{data: 0, last: 0, user: 0};
    e1 = e0;
    if (qa.size() > 0) e0 = qa[0];
    if (qb.size() > 0) e1 = qb[0];
    cmp("a", qa.size() > 0, e0, a_m_tvalid, a_m_tdata, a_m_tlast, a_m_tuser, a_m_tstrb,
        a_s_tready, a_err_odd, a_err_ovf, mer_odd[0], mer_ovf[0]);
    cmp("b", qb.size() > 0, e1, b_m_tvalid, b_m_tdata, b_m_tlast, b_m_tuser, b_m_tstrb,
        b_s_tready, b_err_odd, b_err_ovf, mer_odd[1], mer_ovf[1]);
  endtask

  // One clock: compare at negedge, drive, then advance the model for the
  // coming posedge.
  task automatic step(input bit v, input int px, input bit l, input bit u, input bit mr,
                      output bit acc);
    logic [15:0] p16;
    bit ha, hb, acc_a, acc_b;
    @(negedge clk);
    cmp_all();
    p16 = px[15:0];
    s_tvalid = v;
    s_tdata  = {16'hABCD, p16};
    s_tlast  = l;
    s_tuser  = u;
    m_tready = mr;
    #1;
    acc = 1'b0;
    if (resetn) begin
      ha = qa.size() > 0;
      hb = qb.size() > 0;
      acc_a = v && (!ha || mr);
      acc_b = v && (!hb || mr);
      if (ha && mr) capa.push_back(qa.pop_front());
      if (hb && mr) capb.push_back(qb.pop_front());
      if (acc_a) model_beat(0, 128, px, l, u);
      if (acc_b) model_beat(1, 4, px, l, u);
      acc = acc_a;
    end
  endtask

  task automatic send_beat(input int px, input bit l, input bit u, input bit bp);
    bit acc, mr;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      mr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'b1, px, l, u, mr, acc);
    end
    check("beat_accept_timeout", int'(acc), 1);
  endtask

  task automatic drain(input bit bp);
    bit acc, mr;
    for (int t = 0; t < 60 && (qa.size() + qb.size()) > 0; t++) begin
      mr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'b0, 0, 1'b0, 1'b0, mr, acc);
    end
    check("drain_timeout", qa.size() + qb.size(), 0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Sequential pixels start, start+1, ...; only the first nbeats are sent.
  task automatic send_seq(input int w, input int h, input int start, input bit bp, input int nbeats);
    int n;
    n = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (n < nbeats) begin
          send_beat(start + r * w + c, c == w - 1, (r == 0) && (c == 0), bp);
          n++;
        end
  endtask

  task automatic send2x2(input int p0, input int p1, input int p2, input int p3);
    send_beat(p0, 1'b0, 1'b1, 1'b0);
    send_beat(p1, 1'b1, 1'b0, 1'b0);
    send_beat(p2, 1'b0, 1'b0, 1'b0);
    send_beat(p3, 1'b1, 1'b0, 1'b0);
    drain(1'b0);
  endtask

  task automatic exp_a(input string name, input int idx, input int d, input bit l, input bit u);
    if (idx < capa.size()) begin
      check({name, "_data"}, capa[idx].data, d);
      check({name, "_last"}, int'(capa[idx].last), int'(l));
      check({name, "_user"}, int'(capa[idx].user), int'(u));
    end
  endtask

  task automatic exp_b(input string name, input int idx, input int d, input bit l);
    if (idx < capb.size()) begin
      check({name, "_data"}, capb[idx].data, d);
      check({name, "_last"}, int'(capb[idx].last), int'(l));
    end
  endtask

  task automatic do_reset(input int n);
    bit acc;
    @(negedge clk);
    cmp_all();
    resetn   = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    model_reset();
    #1;
    cmp_all();
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
    model_reset();
    do_reset(3);
    check("rst_s_tready", int'(a_s_tready), 1);
    check("rst_m_tvalid", int'(a_m_tvalid), 0);
    check("rst_m_tdata", int'(a_m_tdata), 0);
    check("rst_err_odd", int'(a_err_odd), 0);

    // 4x4 frame 1..16
    send_seq(4, 4, 1, 1'b0, 16);
    drain(1'b0);
    check("f4x4_count", capa.size(), 4);
    exp_a("f4x4_0", 0, 6, 1'b0, 1'b1);
    exp_a("f4x4_1", 1, 8, 1'b1, 1'b0);
    exp_a("f4x4_2", 2, 14, 1'b0, 1'b0);
    exp_a("f4x4_3", 3, 16, 1'b1, 1'b0);
    capa.delete(); capb.delete();

    // ReLU and extreme negative values
    send2x2(-5, 3, -1, -7);
    send2x2(-5, -3, -1, -7);
    send2x2(-32768, 5, -32768, -32768);
    send2x2(-32768, -2, -32768, -32768);
    send2x2(7, -32768, -32768, -32768);
    check("relu_count", capa.size(), 5);
    exp_a("relu_pos", 0, 3, 1'b1, 1'b1);
    exp_a("relu_neg", 1, 0, 1'b1, 1'b1);
    exp_a("min_5", 2, 5, 1'b1, 1'b1);
    exp_a("min_neg2", 3, 0, 1'b1, 1'b1);
    exp_a("min_7", 4, 7, 1'b1, 1'b1);
    capa.delete(); capb.delete();

    // Backpressure
    send_seq(4, 4, 1, 1'b1, 16);
    drain(1'b1);
    check("bp_count", capa.size(), 4);
    exp_a("bp_0", 0, 6, 1'b0, 1'b1);
    exp_a("bp_1", 1, 8, 1'b1, 1'b0);
    exp_a("bp_2", 2, 14, 1'b0, 1'b0);
    exp_a("bp_3", 3, 16, 1'b1, 1'b0);
    capa.delete(); capb.delete();

    // Odd line width 5x2
    send_seq(5, 2, 1, 1'b0, 10);
    drain(1'b0);
    check("odd_count", capa.size(), 2);
    exp_a("odd_0", 0, 7, 1'b0, 1'b1);
    exp_a("odd_1", 1, 9, 1'b0, 1'b0);
    check("odd_err_set", int'(a_err_odd), 1);
    capa.delete(); capb.delete();
    send2x2(1, 2, 3, 4);
    check("odd_err_clear", int'(a_err_odd), 0);
    capa.delete(); capb.delete();

    // Overflow: 6-pixel lines against the 4-pixel instance
    send_seq(6, 2, 1, 1'b0, 12);
    drain(1'b0);
    check("ovf_b_count", capb.size(), 2);
    exp_b("ovf_b_0", 0, 8, 1'b0);
    exp_b("ovf_b_1", 1, 10, 1'b0);
    check("ovf_b_err", int'(b_err_ovf), 1);
    check("ovf_a_err", int'(a_err_ovf), 0);
    check("ovf_a_count", capa.size(), 3);
    exp_a("ovf_a_2", 2, 12, 1'b1, 1'b0);
    capa.delete(); capb.delete();

    // Reset after 1.5 rows, then a clean 2x2 frame
    send_seq(4, 4, 1, 1'b0, 6);
    do_reset(2);
    check("rst_mid_tvalid", int'(a_m_tvalid), 0);
    send2x2(1, 2, 3, 4);
    check("rst_mid_count", capa.size(), 1);
    exp_a("rst_mid_0", 0, 4, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_relu_axis.md
# maxpool_relu_axis

Streaming ReLU and 2x2/stride-2 max-pool stage placed directly downstream of `conv_layer_axis`. It takes the conv result stream, one signed `DATA_WIDTH` pixel per beat, raster order, with `tuser` marking start of frame and `tlast` marking end of line. It emits one pooled, rectified pixel per 2x2 window on an AXI-Stream master. A single-line buffer holds horizontal maxima from even rows until the matching odd row arrives.

## Interface
- `DATA_WIDTH`, 16: signed pixel width, taken from `tdata[DATA_WIDTH-1:0]`.
- `C_AXIS_TDATA_WIDTH`, 32: AXIS data width on both sides.
- `MAX_LINE_WIDTH`, 128: maximum input pixels per line. Must be even. The line buffer has `MAX_LINE_WIDTH/2` entries.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tdata` in `C_AXIS_TDATA_WIDTH`: low `DATA_WIDTH` bits are the pixel. Upper bits are ignored.
- `s_axis_tlast` in 1: last pixel of an input line.
- `s_axis_tuser` in 1: first pixel of a frame.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out `C_AXIS_TDATA_WIDTH`: pooled pixel, zero-extended.
- `m_axis_tstrb` out `C_AXIS_TDATA_WIDTH/8`: constant all ones.
- `m_axis_tlast` out 1: last pixel of an output line.
- `m_axis_tuser` out 1: first output pixel of a frame.
- `err_odd_line` out 1: sticky flag. Set when `tlast` arrives on an even column (odd line length). Cleared by reset or by an accepted `tuser` beat.
- `err_overflow` out 1: sticky flag. Set when a line exceeds `MAX_LINE_WIDTH`. Cleared the same way as `err_odd_line`.

## Operation
- An input beat is accepted when `s_axis_tvalid && s_axis_tready`. Only accepted beats advance state.
- Counters:
  - `col` counts pixels in the current line. It resets to 0 after a `tlast` beat.
  - Row FSM has two states, `ROW_EVEN` and `ROW_ODD`. It toggles on each accepted `tlast` beat.
- Accepted `tuser` beat: forces `row=ROW_EVEN`, `col=0` before the beat is processed, clears both error flags, and arms `first_pending`.
- Horizontal max:
  - Even-column beat: store pixel in `hold`.
  - Odd-column beat: `hmax = max(hold, pixel)`, signed compare.
- In `ROW_EVEN`, on an odd column: write `hmax` to `line_buf[col>>1]`.
- In `ROW_ODD`, on an even column: issue a synchronous read of `line_buf[col>>1]`.
- In `ROW_ODD`, on an odd column: compute `vmax = max(rd_data, hmax)` and `relu = vmax<0 ? 0 : vmax`, then load the output register:
  - `tdata = {zeros, relu}`.
  - `tlast = s_axis_tlast`.
  - `tuser = first_pending`, after which `first_pending` is cleared.
- Odd line length: the trailing pixel is dropped and `err_odd_line` is set. No output `tlast` is generated for that row.
- Columns at or beyond `MAX_LINE_WIDTH`: not written or pooled, and `err_overflow` is set. The counter saturates; it does not wrap.
- Odd frame height: the final even row is buffered and never emitted.
- `line_buf` is not cleared by reset. Every entry is written in an even row before it is read.

## Timing
- Reset values: `s_axis_tready=1` (combinational, see below). `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `m_axis_tuser`, both error flags, `col`, `row=ROW_EVEN`, `first_pending=0`, `hold` are all 0.
- `s_axis_tready = !m_axis_tvalid || m_axis_tready`. This is combinational and has no bubbles.
- Latency: output is valid 1 cycle after the accepted odd-row, odd-column beat.
- `m_axis_tvalid` stays high, and `tdata`/`tlast`/`tuser` stay stable, until `m_axis_tready`.
- A simultaneous output drain and new output load in the same cycle is supported, giving full throughput of 1 input per cycle.
- Reset mid-frame: the pending output is discarded immediately. The next frame must start with `tuser`. Until then, beats are processed from `ROW_EVEN`, col 0.

## Structure
- Shared package `cnn_pkg`: `DATA_WIDTH`, `C_AXIS_TDATA_WIDTH`, a signed pixel typedef, and row-state encodings `ROW_EVEN`/`ROW_ODD`.
- Sub-module `pool_line_buf`: simple dual-port RAM, depth `MAX_LINE_WIDTH/2`, width `DATA_WIDTH`, synchronous write, 1-cycle registered read.

## Test plan
- 4x4 frame, rows 1..4, 5..8, 9..12, 13..16, `tuser` on pixel 1 -> outputs 6 (tuser=1), 8 (tlast), 14, 16 (tlast).
- ReLU: rows [-5,3] and [-1,-7] -> 3. Rows [-5,-3] and [-1,-7] -> 0. Pixel -32768 in any window with a larger value is handled correctly.
- Backpressure: 4x4 frame with `m_axis_tready` toggled randomly -> identical outputs. `s_axis_tready` is low exactly while `m_axis_tvalid && !m_axis_tready`. No beat is lost or duplicated.
- Odd width: 5x2 frame of 1..10 -> outputs 7, 9. No `tlast` on either. `err_odd_line`=1. A following `tuser` clears the flag.
- Overflow at `MAX_LINE_WIDTH`=4: a 6-pixel line pair -> only 2 outputs. `err_overflow`=1.
- Reset mid-frame: assert `resetn`=0 after 1.5 rows -> all outputs are 0 during reset. A subsequent clean 2x2 frame [1,2;3,4] -> single output 4 with tuser=1 and tlast=1.
